id_fetch_queue: RTL and testbench

- Parametrised instruction buffer between IF and ID that replaces the single-entry stall buffer in the decode stage.
- Captures {pc, inst} pairs returned by the synchronous inst SRAM, which has 1-cycle read latency, and holds up to DEPTH of them while ID is stalled, so no fetched word is lost or refetched.
- Presents a valid/ready head entry to ID.
- Discards all queued and in-flight words on a branch flush.

---
 rtl/id_fetch_queue_pkg.sv | 18 +
 rtl/id_fetch_queue_if.sv | 28 ++
 rtl/id_fetch_queue_fq_storage.sv | 23 ++
 rtl/id_fetch_queue.sv | 103 ++++++++++
 tb/tb_id_fetch_queue.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/id_fetch_queue_pkg.sv
// Shared constants and helpers for the IF->ID fetch queue.
package id_fetch_queue_pkg;

    localparam int unsigned FQ_DEPTH    = 4;
    localparam int unsigned FQ_PC_W     = 32;
    localparam int unsigned FQ_INST_W   = 32;
    localparam int unsigned FQ_ENTRY_WD = FQ_PC_W + FQ_INST_W;

    // Pointer carries one extra wrap bit beyond the index.
    function automatic int unsigned fq_ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned fq_entry_wd(input int unsigned pc_w, input int unsigned inst_w);
        return pc_w + inst_w;
    endfunction

endpackage

// File: rtl/id_fetch_queue_if.sv
// IF/SRAM/ID-facing signal bundle of the fetch queue.
interface id_fetch_queue_if #(
    parameter int unsigned DEPTH  = id_fetch_queue_pkg::FQ_DEPTH,
    parameter int unsigned PC_W   = id_fetch_queue_pkg::FQ_PC_W,
    parameter int unsigned INST_W = id_fetch_queue_pkg::FQ_INST_W
);
    logic                      req_fire;
    logic [PC_W-1:0]           req_pc;
    logic [INST_W-1:0]         inst_sram_rdata;
    logic                      flush;
    logic                      can_issue;
    logic                      out_valid;
    logic                      out_ready;
    logic [PC_W-1:0]           out_pc;
    logic [INST_W-1:0]         out_inst;
    logic [$clog2(DEPTH):0]    count;
    logic                      err_overflow;

    modport master (
        output req_fire, req_pc, inst_sram_rdata, flush, out_ready,
        input  can_issue, out_valid, out_pc, out_inst, count, err_overflow
    );

    modport slave (
        input  req_fire, req_pc, inst_sram_rdata, flush, out_ready,
        output can_issue, out_valid, out_pc, out_inst, count, err_overflow
    );
endinterface

// File: rtl/id_fetch_queue_fq_storage.sv
// Entry array: one synchronous write port, one asynchronous read port.
module fq_storage #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the pushed entry; contents need no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/id_fetch_queue.sv
// Instruction buffer between IF and ID: captures SRAM responses, holds them
// while ID stalls, optionally bypasses into an empty queue, kills on flush.
module id_fetch_queue
    import id_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = FQ_DEPTH,
    parameter int unsigned PC_W   = FQ_PC_W,
    parameter int unsigned INST_W = FQ_INST_W,
    parameter bit          BYPASS = 1'b1
) (
    input logic             clk,
    input logic             resetn,
    id_fetch_queue_if.slave bus
);
    localparam int unsigned    PTR_W   = fq_ptr_w(DEPTH);
    localparam int unsigned    IDX_W   = PTR_W - 1;
    localparam int unsigned    ENTRY_W = fq_entry_wd(PC_W, INST_W);
    localparam logic [PTR_W:0] DEPTH_L = DEPTH[PTR_W:0];

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic               inflight_q, inflight_d;
    logic               drop_q, drop_d;
    logic               err_q, err_d;
    logic [PC_W-1:0]    pc_q;
    logic [PTR_W-1:0]   count_w;
    logic [PTR_W:0]     occ;
    logic               empty, can_issue, rsp_v, bypass_head, head_valid;
    logic               push, pop, issue;
    logic [ENTRY_W-1:0] rd_entry, wr_entry, head_entry;

    fq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_storage (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q[IDX_W-1:0]),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q[IDX_W-1:0]),
        .rdata_o (rd_entry)
    );

    // Occupancy, head selection and push/pop qualification.
    always_comb begin
        count_w     = wr_ptr_q - rd_ptr_q;
        empty       = (wr_ptr_q == rd_ptr_q);
        occ         = {1'b0, count_w} + {{PTR_W{1'b0}}, inflight_q};
        can_issue   = (occ < DEPTH_L);
        rsp_v       = inflight_q & ~drop_q;
        bypass_head = BYPASS & empty;
        head_valid  = ~bus.flush & (bypass_head ? rsp_v : ~empty);
        wr_entry    = {pc_q, bus.inst_sram_rdata};
        head_entry  = bypass_head ? wr_entry : rd_entry;
        // A bypassed word taken by ID is never stored and never moves rd_ptr.
        push        = rsp_v & ~bus.flush & ~(bypass_head & bus.out_ready);
        pop         = head_valid & bus.out_ready & ~bypass_head;
        issue       = bus.req_fire & can_issue;
    end

    // Next-state: flush wins over push/pop; a request in the flush cycle survives.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = issue;
        drop_d     = bus.flush & inflight_q & ~issue;
        err_d      = err_q | (bus.req_fire & ~can_issue);
        if (bus.flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            err_q      <= 1'b0;
            pc_q       <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
            pc_q       <= bus.req_pc;
        end
    end

    // Outputs; head data reads as zero whenever no entry is presented.
    always_comb begin
        bus.can_issue    = can_issue;
        bus.out_valid    = head_valid;
        bus.out_pc       = head_valid ? head_entry[ENTRY_W-1 -: PC_W] : '0;
        bus.out_inst     = head_valid ? head_entry[INST_W-1:0] : '0;
        bus.count        = count_w;
        bus.err_overflow = err_q;
    end
endmodule

// File: tb/tb_id_fetch_queue.sv
// Directed bench for id_fetch_queue: DUT A with bypass, DUT B without.
module tb_id_fetch_queue;
    logic        clk = 1'b0;
    logic        resetn, req_fire, flush, out_ready;
    logic [31:0] req_pc, rdata;
    logic [31:0] prev_pc;
    logic        prev_fired;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    id_fetch_queue_if #(.DEPTH(4), .PC_W(32), .INST_W(32)) bus_a ();
    id_fetch_queue_if #(.DEPTH(4), .PC_W(32), .INST_W(32)) bus_b ();

    assign bus_a.req_fire = req_fire;  assign bus_b.req_fire = req_fire;
    assign bus_a.req_pc = req_pc;      assign bus_b.req_pc = req_pc;
    assign bus_a.inst_sram_rdata = rdata; assign bus_b.inst_sram_rdata = rdata;
    assign bus_a.flush = flush;        assign bus_b.flush = flush;
    assign bus_a.out_ready = out_ready; assign bus_b.out_ready = out_ready;

    id_fetch_queue #(.DEPTH(4), .PC_W(32), .INST_W(32), .BYPASS(1'b1)) u_dut_a (
        .clk(clk), .resetn(resetn), .bus(bus_a));
    id_fetch_queue #(.DEPTH(4), .PC_W(32), .INST_W(32), .BYPASS(1'b0)) u_dut_b (
        .clk(clk), .resetn(resetn), .bus(bus_b));

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {16'hA5A5, pc[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue n_fire back-to-back fetches from base over n_cyc cycles with ID stalled.
    task automatic fill(input logic [31:0] base, input int n_fire, input int n_cyc);
        out_ready = 1'b0;
        for (int c = 0; c < n_cyc; c++) begin
            rdata    = prev_fired ? inst_of(prev_pc) : 32'h0;
            req_fire = (c < n_fire);
            req_pc   = base + 32'(4 * c);
            prev_fired = req_fire;
            prev_pc    = req_pc;
            tick();
        end
        req_fire = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; req_fire = 1'b0; flush = 1'b0; out_ready = 1'b0;
        req_pc = '0; rdata = '0; prev_fired = 1'b0; prev_pc = '0;
        #2;
        n_checks++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus_a.out_valid); end
        n_checks++; if (bus_a.count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus_a.count); end
        n_checks++; if (bus_a.can_issue !== 1'b1) begin n_fail++; $display("FAIL reset_can_issue: got %b want 1", bus_a.can_issue); end
        n_checks++; if (bus_a.out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", bus_a.out_pc); end
        n_checks++; if (bus_a.out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", bus_a.out_inst); end
        n_checks++; if (bus_a.err_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus_a.err_overflow); end
        n_checks++; if (bus_b.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_valid: got %b want 0", bus_b.out_valid); end
        @(posedge clk); #3 resetn = 1'b1;
        tick();
    endtask

    task automatic test_single_fetch(input logic [31:0] pc, input logic [31:0] inst);
        out_ready = 1'b1; req_fire = 1'b1; req_pc = pc;
        tick();
        req_fire = 1'b0; rdata = inst; #1;
        n_checks++; if (bus_a.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_a_valid_n1: got %b want 1", bus_a.out_valid); end
        n_checks++; if (bus_a.out_pc !== pc) begin n_fail++; $display("FAIL single_a_pc: got %h want %h", bus_a.out_pc, pc); end
        n_checks++; if (bus_a.out_inst !== inst) begin n_fail++; $display("FAIL single_a_inst: got %h want %h", bus_a.out_inst, inst); end
        n_checks++; if (bus_b.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_b_valid_n1: got %b want 0", bus_b.out_valid); end
        tick(); #1;
        n_checks++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_a_valid_n2: got %b want 0", bus_a.out_valid); end
        n_checks++; if (bus_a.count !== 3'd0) begin n_fail++; $display("FAIL single_a_count: got %0d want 0", bus_a.count); end
        n_checks++; if (bus_b.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_b_valid_n2: got %b want 1", bus_b.out_valid); end
        n_checks++; if (bus_b.out_pc !== pc) begin n_fail++; $display("FAIL single_b_pc: got %h want %h", bus_b.out_pc, pc); end
        n_checks++; if (bus_b.out_inst !== inst) begin n_fail++; $display("FAIL single_b_inst: got %h want %h", bus_b.out_inst, inst); end
        n_checks++; if (bus_b.count !== 3'd1) begin n_fail++; $display("FAIL single_b_count: got %0d want 1", bus_b.count); end
        tick(); #1;
        n_checks++; if (bus_b.count !== 3'd0) begin n_fail++; $display("FAIL single_b_drained: got %0d want 0", bus_b.count); end
        out_ready = 1'b0;
    endtask

    task automatic test_stall_fill();
        logic exp_ci [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] pc_next = 32'h100;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rdata    = prev_fired ? inst_of(prev_pc) : 32'h0;
            req_fire = exp_ci[i];
            req_pc   = pc_next;
            #1;
            n_checks++; if (bus_a.can_issue !== exp_ci[i]) begin n_fail++; $display("FAIL fill_can_issue[%0d]: got %b want %b", i, bus_a.can_issue, exp_ci[i]); end
            prev_fired = req_fire; prev_pc = req_pc;
            if (req_fire) pc_next = pc_next + 32'd4;
            tick();
        end
        req_fire = 1'b0; #1;
        n_checks++; if (bus_a.count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", bus_a.count); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (bus_a.out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b want 1", i, bus_a.out_valid); end
            n_checks++; if (bus_a.out_pc !== 32'h100 + 32'(4 * i)) begin n_fail++; $display("FAIL drain_pc[%0d]: got %h want %h", i, bus_a.out_pc, 32'h100 + 32'(4 * i)); end
            n_checks++; if (bus_a.out_inst !== inst_of(32'h100 + 32'(4 * i))) begin n_fail++; $display("FAIL drain_inst[%0d]: got %h want %h", i, bus_a.out_inst, inst_of(32'h100 + 32'(4 * i))); end
            tick();
        end
        #1;
        n_checks++; if (bus_a.count !== 3'd0) begin n_fail++; $display("FAIL drain_count: got %0d want 0", bus_a.count); end
        n_checks++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty_valid: got %b want 0", bus_a.out_valid); end
        out_ready = 1'b0; prev_fired = 1'b0;
    endtask

    task automatic test_full_pushpop();
        fill(32'h300, 4, 4);
        rdata = inst_of(32'h30C); out_ready = 1'b1; #1;
        n_checks++; if (bus_a.count !== 3'd3) begin n_fail++; $display("FAIL pp_count_pre: got %0d want 3", bus_a.count); end
        n_checks++; if (bus_a.can_issue !== 1'b0) begin n_fail++; $display("FAIL pp_can_issue: got %b want 0", bus_a.can_issue); end
        n_checks++; if (bus_a.out_pc !== 32'h300) begin n_fail++; $display("FAIL pp_head0: got %h want 300", bus_a.out_pc); end
        tick();
        for (int i = 1; i < 4; i++) begin
            #1;
            n_checks++; if (bus_a.count !== 3'(4 - i)) begin n_fail++; $display("FAIL pp_count[%0d]: got %0d want %0d", i, bus_a.count, 4 - i); end
            n_checks++; if (bus_a.out_pc !== 32'h300 + 32'(4 * i)) begin n_fail++; $display("FAIL pp_head[%0d]: got %h want %h", i, bus_a.out_pc, 32'h300 + 32'(4 * i)); end
            n_checks++; if (bus_a.out_inst !== inst_of(32'h300 + 32'(4 * i))) begin n_fail++; $display("FAIL pp_inst[%0d]: got %h want %h", i, bus_a.out_inst, inst_of(32'h300 + 32'(4 * i))); end
            tick();
        end
        #1;
        n_checks++; if (bus_a.count !== 3'd0) begin n_fail++; $display("FAIL pp_count_end: got %0d want 0", bus_a.count); end
        out_ready = 1'b0; prev_fired = 1'b0;
    endtask

    task automatic test_flush();
        fill(32'h400, 3, 3);
        flush = 1'b1; req_fire = 1'b1; req_pc = 32'h200; rdata = inst_of(32'h408); out_ready = 1'b1; #1;
        n_checks++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid_forced: got %b want 0", bus_a.out_valid); end
        n_checks++; if (bus_a.count !== 3'd2) begin n_fail++; $display("FAIL flush_count_pre: got %0d want 2", bus_a.count); end
        tick();
        flush = 1'b0; req_fire = 1'b0; rdata = inst_of(32'h200); out_ready = 1'b0; #1;
        n_checks++; if (bus_a.count !== 3'd0) begin n_fail++; $display("FAIL flush_a_count: got %0d want 0", bus_a.count); end
        n_checks++; if (bus_a.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_a_redirect_valid: got %b want 1", bus_a.out_valid); end
        n_checks++; if (bus_a.out_pc !== 32'h200) begin n_fail++; $display("FAIL flush_a_pc: got %h want 200", bus_a.out_pc); end
        n_checks++; if (bus_b.count !== 3'd0) begin n_fail++; $display("FAIL flush_b_count: got %0d want 0", bus_b.count); end
        n_checks++; if (bus_b.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_b_valid: got %b want 0", bus_b.out_valid); end
        tick();
        out_ready = 1'b1; #1;
        n_checks++; if (bus_a.count !== 3'd1) begin n_fail++; $display("FAIL flush_a_stored: got %0d want 1", bus_a.count); end
        n_checks++; if (bus_a.out_pc !== 32'h200) begin n_fail++; $display("FAIL flush_a_head: got %h want 200", bus_a.out_pc); end
        n_checks++; if (bus_b.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_b_valid2: got %b want 1", bus_b.out_valid); end
        n_checks++; if (bus_b.out_pc !== 32'h200) begin n_fail++; $display("FAIL flush_b_pc: got %h want 200", bus_b.out_pc); end
        n_checks++; if (bus_b.out_inst !== inst_of(32'h200)) begin n_fail++; $display("FAIL flush_b_inst: got %h want %h", bus_b.out_inst, inst_of(32'h200)); end
        tick(); #1;
        n_checks++; if (bus_a.count !== 3'd0) begin n_fail++; $display("FAIL flush_a_end: got %0d want 0", bus_a.count); end
        n_checks++; if (bus_b.count !== 3'd0) begin n_fail++; $display("FAIL flush_b_end: got %0d want 0", bus_b.count); end
        out_ready = 1'b0; prev_fired = 1'b0;
    endtask

    task automatic test_overflow();
        fill(32'h500, 4, 4);
        rdata = inst_of(32'h50C); req_fire = 1'b1; req_pc = 32'h600; #1;
        n_checks++; if (bus_a.can_issue !== 1'b0) begin n_fail++; $display("FAIL ovf_can_issue: got %b want 0", bus_a.can_issue); end
        n_checks++; if (bus_a.err_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_err_pre: got %b want 0", bus_a.err_overflow); end
        tick();
        req_fire = 1'b0; #1;
        n_checks++; if (bus_a.err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_err_set: got %b want 1", bus_a.err_overflow); end
        n_checks++; if (bus_a.count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d want 4", bus_a.count); end
        tick(); #1;
        n_checks++; if (bus_a.err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_err_sticky: got %b want 1", bus_a.err_overflow); end
        n_checks++; if (bus_a.count !== 3'd4) begin n_fail++; $display("FAIL ovf_count_hold: got %0d want 4", bus_a.count); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (bus_a.out_pc !== 32'h500 + 32'(4 * i)) begin n_fail++; $display("FAIL ovf_drain_pc[%0d]: got %h want %h", i, bus_a.out_pc, 32'h500 + 32'(4 * i)); end
            tick();
        end
        #1;
        n_checks++; if (bus_a.count !== 3'd0) begin n_fail++; $display("FAIL ovf_drain_count: got %0d want 0", bus_a.count); end
        n_checks++; if (bus_a.err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_err_after: got %b want 1", bus_a.err_overflow); end
        out_ready = 1'b0; prev_fired = 1'b0;
    endtask

    task automatic test_async_reset();
        fill(32'h700, 3, 4);
        #1;
        n_checks++; if (bus_a.count !== 3'd3) begin n_fail++; $display("FAIL ar_count_pre: got %0d want 3", bus_a.count); end
        n_checks++; if (bus_a.out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_valid_pre: got %b want 1", bus_a.out_valid); end
        #2 resetn = 1'b0;
        #1;
        n_checks++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", bus_a.out_valid); end
        n_checks++; if (bus_a.count !== 3'd0) begin n_fail++; $display("FAIL ar_count: got %0d want 0", bus_a.count); end
        n_checks++; if (bus_a.can_issue !== 1'b1) begin n_fail++; $display("FAIL ar_can_issue: got %b want 1", bus_a.can_issue); end
        n_checks++; if (bus_a.err_overflow !== 1'b0) begin n_fail++; $display("FAIL ar_err: got %b want 0", bus_a.err_overflow); end
        n_checks++; if (bus_b.count !== 3'd0) begin n_fail++; $display("FAIL ar_b_count: got %0d want 0", bus_b.count); end
        rdata = '0; prev_fired = 1'b0;
        @(posedge clk); #3 resetn = 1'b1;
        tick();
        test_single_fetch(32'h800, 32'h3C1D0002);
    endtask

    initial begin
        test_reset();
        test_single_fetch(32'hBFC00000, 32'h3C1D0001);
        test_stall_fill();
        test_full_pushpop();
        test_flush();
        test_overflow();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
